// File: rtl/chacha_pkg.sv
// Shared constants, types and helpers for the ChaCha block core.
package chacha_pkg;

  localparam logic [31:0] SIGMA [4] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
  };

  typedef logic [15:0][31:0] state_t;
  typedef logic [3:0][31:0]  quad_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } fsm_t;

  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  function automatic logic [31:0] rotl32(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x << n) | (x >> (32 - n));
  endfunction

  // q[2] picks the diagonal half, q[1:0] the quarter round within it
  function automatic logic [3:0] qr_idx(
    input logic [2:0] q,
    input logic [1:0] k
  );
    return q[2] ? DIAG_IDX[q[1:0]][k] : COL_IDX[q[1:0]][k];
  endfunction

endpackage

// File: rtl/chacha_qr_lane.sv
// Combinational ChaCha quarter round on four 32-bit words.
module chacha_qr_lane (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_new,
  output logic [31:0] b_new,
  output logic [31:0] c_new,
  output logic [31:0] d_new
);
  import chacha_pkg::*;

  logic [31:0] a1, b1, c1, d1;

  assign a1    = a + b;
  assign d1    = rotl32(d ^ a1, 16);
  assign c1    = c + d1;
  assign b1    = rotl32(b ^ c1, 12);
  assign a_new = a1 + b1;
  assign d_new = rotl32(d1 ^ a_new, 8);
  assign c_new = c1 + d_new;
  assign b_new = rotl32(b1 ^ c_new, 7);

endmodule

// File: rtl/chacha_block_core.sv
// Sequential ChaCha block function: one 512-bit keystream block per request.
module chacha_block_core #(
  parameter int ROUNDS       = 20,
  parameter int QR_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         busy
);
  import chacha_pkg::*;

  if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
    $error("ROUNDS must be 8, 12 or 20");
  end
  if (!(QR_PER_CYCLE == 1 || QR_PER_CYCLE == 2 || QR_PER_CYCLE == 4)) begin : g_bad_qpc
    $error("QR_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int NSTEP = 4 * ROUNDS / QR_PER_CYCLE;
  localparam int PW    = $clog2(NSTEP);
  localparam logic [PW-1:0] LAST = PW'(NSTEP - 1);

  fsm_t          state, state_n;
  logic [PW-1:0] phase;
  state_t        work, saved, init, nxt, out_reg;
  logic [2:0]    sel [QR_PER_CYCLE];
  quad_t         lane_in [QR_PER_CYCLE];
  quad_t         lane_out [QR_PER_CYCLE];

  always_comb begin
    for (int i = 0; i < 4; i++) init[i] = SIGMA[i];
    for (int i = 0; i < 8; i++) init[4+i] = key[32*i +: 32];
    init[12] = counter;
    for (int j = 0; j < 3; j++) init[13+j] = nonce[32*j +: 32];
  end

  // QR slot is (phase*QR_PER_CYCLE + lane) mod 8: slots 0-3 column, 4-7 diagonal
  always_comb begin
    for (int l = 0; l < QR_PER_CYCLE; l++) begin
      sel[l] = 3'((int'(phase) * QR_PER_CYCLE + l) % 8);
      for (int k = 0; k < 4; k++) begin
        lane_in[l][k] = work[qr_idx(sel[l], 2'(k))];
      end
    end
  end

  for (genvar l = 0; l < QR_PER_CYCLE; l++) begin : g_lane
    chacha_qr_lane u_lane (
      .a     (lane_in[l][0]),
      .b     (lane_in[l][1]),
      .c     (lane_in[l][2]),
      .d     (lane_in[l][3]),
      .a_new (lane_out[l][0]),
      .b_new (lane_out[l][1]),
      .c_new (lane_out[l][2]),
      .d_new (lane_out[l][3])
    );
  end

  always_comb begin
    nxt = work;
    for (int l = 0; l < QR_PER_CYCLE; l++) begin
      for (int k = 0; k < 4; k++) begin
        nxt[qr_idx(sel[l], 2'(k))] = lane_out[l][k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid) state_n = ROUND;
      ROUND:   if (phase == LAST) state_n = FINAL;
      FINAL:   state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      saved     <= '0;
      phase     <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= init;
            saved <= init;
            phase <= '0;
          end
        end
        ROUND: begin
          work  <= nxt;
          phase <= phase + PW'(1);
        end
        FINAL: begin
          for (int i = 0; i < 16; i++) begin
            out_reg[i] <= work[i] + saved[i];
          end
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == ROUND) || (state == FINAL);
  assign out_block = out_reg;

endmodule

// File: tb/tb_chacha_block_core.sv
// Randomised bench for chacha_block_core across several ROUNDS/QR_PER_CYCLE builds.
module tb_chacha_block_core;

  localparam int NI = 5;
  localparam int RA [NI] = '{20, 20, 20, 8, 12};
  localparam int QA [NI] = '{1, 2, 4, 2, 4};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [255:0] key;
  logic [31:0]  counter;
  logic [95:0]  nonce;
  logic         iv  [NI];
  logic         ory [NI];
  logic         rdy [NI];
  logic         ov  [NI];
  logic         bsy [NI];
  logic [511:0] ob  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    chacha_block_core #(
      .ROUNDS       (RA[g]),
      .QR_PER_CYCLE (QA[g])
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (rdy[g]),
      .key       (key),
      .counter   (counter),
      .nonce     (nonce),
      .out_valid (ov[g]),
      .out_ready (ory[g]),
      .out_block (ob[g]),
      .busy      (bsy[g])
    );
  end

  logic [31:0] la, lb, lc, ld, na, nb, nc, nd;

  chacha_qr_lane u_lane (
    .a     (la),
    .b     (lb),
    .c     (lc),
    .d     (ld),
    .a_new (na),
    .b_new (nb),
    .c_new (nc),
    .d_new (nd)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] model(input logic [255:0] k,
                                         input logic [31:0] c,
                                         input logic [95:0] n,
                                         input int rounds);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [511:0] r;
    int q [8][4] = '{
      '{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
      '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}
    };
    s[0] = 32'h61707865;
    s[1] = 32'h3320646e;
    s[2] = 32'h79622d32;
    s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
    x = s;
    for (int dr = 0; dr < rounds / 2; dr++) begin
      for (int h = 0; h < 8; h++) begin
        int a, b, cc, d;
        a = q[h][0]; b = q[h][1]; cc = q[h][2]; d = q[h][3];
        x[a]  = x[a] + x[b];   x[d] = rl(x[d] ^ x[a], 16);
        x[cc] = x[cc] + x[d];  x[b] = rl(x[b] ^ x[cc], 12);
        x[a]  = x[a] + x[b];   x[d] = rl(x[d] ^ x[a], 8);
        x[cc] = x[cc] + x[d];  x[b] = rl(x[b] ^ x[cc], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [95:0] rnd96();
    logic [95:0] v;
    for (int i = 0; i < 3; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic run(input int i, input logic [255:0] k, input logic [31:0] c,
                     input logic [95:0] n, input bit hs,
                     output logic [511:0] blk);
    int lat;
    @(negedge clk);
    check($sformatf("in_ready_before_req%0d", i), 512'(rdy[i]), 512'(1));
    key = k; counter = c; nonce = n; iv[i] = 1'b1;
    @(posedge clk); #1;
    iv[i] = 1'b0;
    key = rnd256(); counter = $urandom(); nonce = rnd96();
    lat = 0;
    while (!ov[i] && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency%0d", i), 512'(lat), 512'(4 * RA[i] / QA[i] + 1));
    blk = ob[i];
    if (hs) begin
      @(negedge clk); ory[i] = 1'b1;
      @(posedge clk); #1; ory[i] = 1'b0;
      check($sformatf("in_ready_after_hs%0d", i), 512'(rdy[i]), 512'(1));
      check($sformatf("out_valid_after_hs%0d", i), 512'(ov[i]), 512'(0));
    end
  endtask

  logic [255:0] rk;
  logic [95:0]  rn;
  logic [511:0] blk, held;
  logic [255:0] k0;
  logic [31:0]  c0;
  logic [95:0]  n0;

  initial begin
    for (int i = 0; i < NI; i++) begin iv[i] = 1'b0; ory[i] = 1'b0; end
    key = '0; counter = '0; nonce = '0;
    la = '0; lb = '0; lc = '0; ld = '0;
    for (int b = 0; b < 32; b++) rk[8*b +: 8] = 8'(b);
    rn = {32'h00000000, 32'h4a000000, 32'h09000000};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_in_ready%0d", i), 512'(rdy[i]), 512'(1));
      check($sformatf("reset_out_valid%0d", i), 512'(ov[i]), 512'(0));
      check($sformatf("reset_busy%0d", i), 512'(bsy[i]), 512'(0));
      check($sformatf("reset_out_block%0d", i), ob[i], 512'(0));
    end

    la = 32'h11111111; lb = 32'h01020304; lc = 32'h9b8d6f43; ld = 32'h01234567;
    #1;
    check("lane_a", 512'(na), 512'(32'hea2a92f4));
    check("lane_b", 512'(nb), 512'(32'hcb1cf8ce));
    check("lane_c", 512'(nc), 512'(32'h4581472e));
    check("lane_d", 512'(nd), 512'(32'h5881c4bb));

    for (int i = 0; i < 3; i++) begin
      run(i, rk, 32'h1, rn, 1'b1, blk);
      check($sformatf("rfc_w0_%0d", i), 512'(blk[31:0]), 512'(32'he4e7f110));
      check($sformatf("rfc_w1_%0d", i), 512'(blk[63:32]), 512'(32'h15593bd1));
      check($sformatf("rfc_w15_%0d", i), 512'(blk[511:480]), 512'(32'h4e3c50a2));
      check($sformatf("rfc_full_%0d", i), blk, model(rk, 32'h1, rn, 20));
    end

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NI; i++) begin
        k0 = rnd256(); c0 = $urandom(); n0 = rnd96();
        run(i, k0, c0, n0, 1'b1, blk);
        check($sformatf("rand%0d_inst%0d", r, i), blk, model(k0, c0, n0, RA[i]));
      end
    end

    for (int m = 0; m < 3; m++) begin
      int i;
      i = (m == 0) ? 0 : (m == 1) ? 3 : 4;
      run(i, '0, 32'hffffffff, '0, 1'b1, blk);
      check($sformatf("ctr_wrap_inst%0d", i), blk, model('0, 32'hffffffff, '0, RA[i]));
    end

    k0 = rnd256(); c0 = $urandom(); n0 = rnd96();
    run(2, k0, c0, n0, 1'b0, held);
    check("bp_block", held, model(k0, c0, n0, 20));
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk); iv[2] = cyc[0];
      @(posedge clk); #1;
      check($sformatf("bp_hold_c%0d", cyc), ob[2], held);
      check($sformatf("bp_valid_c%0d", cyc), 512'(ov[2]), 512'(1));
      check($sformatf("bp_in_ready_c%0d", cyc), 512'(rdy[2]), 512'(0));
    end
    @(negedge clk); iv[2] = 1'b0; ory[2] = 1'b1;
    @(posedge clk); #1; ory[2] = 1'b0;
    check("bp_release_ready", 512'(rdy[2]), 512'(1));
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_new_accept", 512'(bsy[2]), 512'(0));

    @(negedge clk);
    key = rk; counter = 32'h1; nonce = rn; iv[0] = 1'b1;
    @(posedge clk); #1; iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 512'(ov[0]), 512'(0));
    @(negedge clk); rst = 1'b0;
    check("rst_mid_in_ready", 512'(rdy[0]), 512'(1));
    check("rst_mid_busy", 512'(bsy[0]), 512'(0));
    repeat (100) @(posedge clk);
    #1;
    check("rst_mid_no_output", 512'(ov[0]), 512'(0));
    run(0, rk, 32'h1, rn, 1'b1, blk);
    check("rst_then_rfc", blk, model(rk, 32'h1, rn, 20));

    begin : b2b
      int acc [$];
      logic [511:0] expq [$];
      logic [511:0] gotq [$];
      int t;
      t = 0;
      @(negedge clk); ory[1] = 1'b1; iv[1] = 1'b1;
      while (t < 300 && gotq.size() < 2) begin
        if (ov[1]) gotq.push_back(ob[1]);
        if (gotq.size() == 2) iv[1] = 1'b0;
        if (rdy[1] && iv[1]) begin
          key = rnd256(); counter = $urandom(); nonce = rnd96();
          acc.push_back(t);
          expq.push_back(model(key, counter, nonce, 20));
        end
        @(negedge clk);
        t++;
      end
      iv[1] = 1'b0; ory[1] = 1'b0;
      check("b2b_accepts", 512'(acc.size()), 512'(2));
      check("b2b_outputs", 512'(gotq.size()), 512'(2));
      if (acc.size() == 2) check("b2b_spacing", 512'(acc[1] - acc[0]), 512'(43));
      for (int j = 0; j < 2; j++) begin
        if (j < gotq.size() && j < expq.size())
          check($sformatf("b2b_block%0d", j), gotq[j], expq[j]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chacha_block_core.md
# chacha_block_core

Sequential ChaCha block function: accepts a 256-bit key, 32-bit block counter and 96-bit nonce, and produces one 512-bit keystream block. It iterates quarter rounds over a 16-word state held in registers, with round count and quarter rounds per cycle set by parameters. It is the successor to the purely combinational quarter-round stage and sits between the seed/key loader and the output whitening/serialiser of the random number generator.

## Interface
- `ROUNDS`, default 20: total rounds. Legal values: 8, 12, 20 (even, ≥2). Elaboration error otherwise.
- `QR_PER_CYCLE`, default 1: quarter rounds evaluated per clock. Legal values: 1, 2, 4. Elaboration error otherwise.
- `clk`, input, 1: clock. Single clock domain.
- `rst`, input, 1: reset. Asynchronous and active-high.
- `in_valid`, input, 1: request valid.
- `in_ready`, output, 1: the core accepts a request. High only in IDLE.
- `key`, input, 256: key word i = `key[32i+31:32i]`, i=0..7.
- `counter`, input, 32: block counter.
- `nonce`, input, 96: nonce word j = `nonce[32j+31:32j]`, j=0..2.
- `out_valid`, output, 1: `out_block` valid.
- `out_ready`, input, 1: downstream accepts.
- `out_block`, output, 512: output word i = `out_block[32i+31:32i]`, i=0..15.
- `busy`, output, 1: high in ROUND or FINAL.

## Operation
- Initial state words:
  - 0..3 = 61707865, 3320646e, 79622d32, 6b206574.
  - 4..11 = key words 0..7.
  - 12 = counter.
  - 13..15 = nonce words 0..2.
- Quarter round on (a,b,c,d), all arithmetic mod 2^32:
  - a+=b; d^=a; d<<<=16
  - c+=d; b^=c; b<<<=12
  - a+=b; d^=a; d<<<=8
  - c+=d; b^=c; b<<<=7
- Double round = column half then diagonal half.
  - Column QRs: (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
  - Diagonal QRs: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
- Scheduling:
  - Each cycle evaluates QR_PER_CYCLE consecutive QRs of the current half, in index order.
  - QRs within a half are disjoint, so the result does not depend on QR_PER_CYCLE.
- Phase counter runs from 0 to NSTEP−1, where NSTEP = 4·ROUNDS/QR_PER_CYCLE. Its width is $clog2(NSTEP).
- FSM:
  - IDLE: in_ready=1. On in_valid, load the working state and a saved copy of the initial state, clear the phase counter, go to ROUND.
  - ROUND: update the working state each cycle and increment phase. At phase NSTEP−1, go to FINAL.
  - FINAL: out_block ← working + initial, word-wise mod 2^32. Set out_valid. Go to DONE.
  - DONE: hold out_valid=1 and out_block stable. On out_ready, clear out_valid and go to IDLE.
- in_valid in any non-IDLE state is ignored. Inputs are sampled only at the accepting edge; later changes to them have no effect.
- Counter wrap (FFFFFFFF) has no special handling. The core never increments the counter.

## Timing
- Reset values:
  - state = IDLE, so in_ready=1.
  - out_valid=0, busy=0, out_block=0.
  - Working state, saved state and phase = 0.
- Reset asserted in any state aborts the block: no out_valid, and the partial state is discarded.
- Latency: request accepted at edge E gives out_valid=1 after edge E+NSTEP+1.
  - ROUNDS=20, QR_PER_CYCLE=1: 81 cycles.
  - ROUNDS=20, QR_PER_CYCLE=4: 21 cycles.
  - ROUNDS=8, QR_PER_CYCLE=2: 17 cycles.
- out_ready high on the first out_valid cycle: handshake completes on that edge, in_ready=1 on the next cycle.
- Minimum request spacing is NSTEP+3 cycles. No overlap between blocks.
- out_ready high while out_valid=0 has no effect.

## Structure
- Package `chacha_pkg`:
  - `SIGMA` constant array (4×32).
  - `state_t` (16×32 array).
  - Column and diagonal index tables.
  - `rotl32` function.
  - FSM state enum.
- Sub-module `chacha_qr_lane`: a combinational quarter round on four 32-bit words, instantiated QR_PER_CYCLE times. Word selection and writeback muxing are driven from the phase counter in the top level.

## Test plan
- RFC 8439 §2.3.2 vector: key bytes 00..1f (word4=03020100), counter=1, nonce words 09000000, 4a000000, 00000000, ROUNDS=20.
  - Required: word0=e4e7f110, word1=15593bd1, word15=4e3c50a2.
  - Required for every QR_PER_CYCLE value, with latency 81/41/21.
- Lane unit test on chacha_qr_lane: a=11111111, b=01020304, c=9b8d6f43, d=01234567 → ea2a92f4, cb1cf8ce, 4581472e, 5881c4bb.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: out_block stable and in_ready=0 throughout; pulsing in_valid causes no new acceptance.
- Reset mid-ROUND at phase 5:
  - Required: out_valid stays 0, in_ready=1 after reset.
  - A fresh RFC request then yields the correct block.
- Counter=ffffffff with zero key and nonce, ROUNDS 8/12/20: output matches the software model, and no carry into nonce words.
- Back-to-back requests with in_valid held high and out_ready=1: second accept occurs exactly NSTEP+3 cycles after the first, and both outputs are correct.
